// File: rtl/sub32_pkg.sv
// Shared constants and FSM state type for the sequential 32-bit subtractor.
// Imported by the top and the slice sub-module.
package sub32_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_sub32_sub_slice.sv
// Combinational SLICE_W-bit subtractor with borrow chain.
// One instance is reused for every slice of the 32-bit operation.
module sub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               bin_i,
  output logic [SLICE_W-1:0] d_o,
  output logic               bout_o
);

  logic [SLICE_W:0] full;

  // Borrow-out falls out as the extra top bit of the widened difference.
  always_comb begin
    full = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_W{1'b0}}, bin_i};
  end

  assign d_o    = full[SLICE_W-1:0];
  assign bout_o = full[SLICE_W];

endmodule

// File: rtl/seq_sub32.sv
// Sequential 32-bit subtractor, SLICE_W bits per clock, IDLE/RUN/DONE FSM.
// Define SEQ_SUB32_FLAGS_EN to build the zero and ovf flag logic.
module seq_sub32
  import sub32_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NS = WIDTH / SLICE_W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, b_q, d_q, d_d;
  logic [CW-1:0]      cnt_q;
  logic               borrow_q;
  logic               bout_q;
  logic [SLICE_W-1:0] sa, sb, sd;
  logic               sbo;
  logic               accept;
  logic               last;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(NS - 1));

  // Select the current slice of the captured operands and merge its result.
  generate
    if (NS == 1) begin : g_one
      assign sa = a_q;
      assign sb = b_q;
      always_comb begin
        d_d = sd;
      end
    end else begin : g_multi
      logic [4:0] base;
      assign base = 5'(cnt_q) * 5'(SLICE_W);
      assign sa   = a_q[base +: SLICE_W];
      assign sb   = b_q[base +: SLICE_W];
      always_comb begin
        d_d = d_q;
        d_d[base +: SLICE_W] = sd;
      end
    end
  endgenerate

  sub_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .a_i   (sa),
    .b_i   (sb),
    .bin_i (borrow_q),
    .d_o   (sd),
    .bout_o(sbo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy in RUN, single-cycle done in DONE.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operand capture and slice-by-slice datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      cnt_q    <= '0;
      borrow_q <= Bin;
    end else if (state_q == RUN) begin
      d_q      <= d_d;
      cnt_q    <= cnt_q + CW'(1);
      borrow_q <= sbo;
      if (last) bout_q <= sbo;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;

`ifdef SEQ_SUB32_FLAGS_EN
  logic zero_q, ovf_q;

  // Flags are latched with the final slice so they hold until next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == RUN && last) begin
      zero_q <= (d_d == '0);
      ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                (d_d[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_sub32.sv
// Self-checking bench for seq_sub32: directed table, corner sequences,
// and random back-to-back runs at several slice widths.
module tb_seq_sub32;

  localparam int NI = 4;
  localparam int SWS [NI] = '{8, 1, 4, 32};

`ifdef SEQ_SUB32_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0]       start_v, bin_v;
  logic [NI-1:0]       busy_v, done_v, bout_v, zero_v, ovf_v;
  logic [NI-1:0][31:0] a_v, b_v, d_v;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_sub32 #(
      .SLICE_W(SWS[g])
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start_v[g]),
      .a    (a_v[g]),
      .b    (b_v[g]),
      .Bin  (bin_v[g]),
      .busy (busy_v[g]),
      .done (done_v[g]),
      .D    (d_v[g]),
      .Bout (bout_v[g]),
      .zero (zero_v[g]),
      .ovf  (ovf_v[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic, signed range test for ovf.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic bin, output logic [31:0] d,
                                output logic bo, output logic z,
                                output logic ov);
    longint ur, sr;
    ur = longint'(a) - longint'(b) - longint'(bin);
    sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    d  = ur[31:0];
    bo = (ur < 0);
    z  = FL && (d == 32'd0);
    ov = FL && (sr < -64'sd2147483648 || sr > 64'sd2147483647);
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic bin);
    start_v[idx] = 1'b1;
    a_v[idx]     = a;
    b_v[idx]     = b;
    bin_v[idx]   = bin;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, output int lat, output bit bok);
    lat = 0;
    bok = 1'b1;
    while (!done_v[idx] && lat < 300) begin
      if (!busy_v[idx]) bok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int          lat, ndone, first;
    bit          bok;
    logic [31:0] ed, dgot;
    logic        ebo, ez, eov;

    tbl[0] = '{32'd5,        32'd3,        1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'd0,        32'd1,        1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, FL};
    tbl[3] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, FL,   1'b0};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b0, FL};
    tbl[7] = '{32'h80000000, 32'd0,        1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, FL};

    start_v = '0;
    bin_v   = '0;
    a_v     = '0;
    b_v     = '0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_D", d_v[0], 32'd0);
    chk("rst_flags", {27'd0, busy_v[0], done_v[0], bout_v[0],
                      zero_v[0], ovf_v[0]}, 32'd0);
    rst = 1'b0;

    // Directed table on the SLICE_W=8 instance.
    for (int i = 0; i < 8; i++) begin
      issue(0, tbl[i].a, tbl[i].b, tbl[i].bin);
      wait_done(0, lat, bok);
      chk($sformatf("t%0d_lat", i), lat, 32'd4);
      chk($sformatf("t%0d_busy", i), {31'd0, bok}, 32'd1);
      chk($sformatf("t%0d_D", i), d_v[0], tbl[i].d);
      chk($sformatf("t%0d_Bout", i), {31'd0, bout_v[0]}, {31'd0, tbl[i].bo});
      chk($sformatf("t%0d_zero", i), {31'd0, zero_v[0]}, {31'd0, tbl[i].z});
      chk($sformatf("t%0d_ovf", i), {31'd0, ovf_v[0]}, {31'd0, tbl[i].ov});
      @(posedge clk);
      #1;
      chk($sformatf("t%0d_pulse", i), {31'd0, done_v[0]}, 32'd0);
      chk($sformatf("t%0d_hold", i), d_v[0], tbl[i].d);
    end

    // Start during RUN must be ignored.
    issue(0, 32'd100, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    a_v[0]     = 32'd7777;
    b_v[0]     = 32'd5;
    bin_v[0]   = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    ndone = 0;
    first = -1;
    dgot  = '0;
    for (int j = 2; j <= 12; j++) begin
      if (done_v[0]) begin
        ndone++;
        if (first < 0) begin
          first = j;
          dgot  = d_v[0];
        end
      end
      @(posedge clk);
      #1;
    end
    chk("ign_ndone", ndone, 32'd1);
    chk("ign_lat", first, 32'd4);
    chk("ign_D", dgot, 32'd99);

    // Reset mid-operation aborts with no done.
    issue(0, 32'h0000AAAA, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_D", d_v[0], 32'd0);
    chk("abort_flags", {27'd0, busy_v[0], done_v[0], bout_v[0],
                        zero_v[0], ovf_v[0]}, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ndone = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) ndone++;
    end
    chk("abort_nodone", ndone, 32'd0);
    issue(0, 32'd10, 32'd4, 1'b0);
    wait_done(0, lat, bok);
    chk("after_rst_lat", lat, 32'd4);
    chk("after_rst_D", d_v[0], 32'd6);

    // Random back-to-back operations at every slice width.
    for (int k = 0; k < NI; k++) begin
      int          nops, ns;
      logic [31:0] ra, rb;
      logic        rbin;
      nops = (k == 0) ? 200 : 1000;
      ns   = 32 / SWS[k];
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(0, 1));
      model(ra, rb, rbin, ed, ebo, ez, eov);
      issue(k, ra, rb, rbin);
      for (int i = 0; i < nops; i++) begin
        wait_done(k, lat, bok);
        chk($sformatf("r%0d_%0d_lat", SWS[k], i), lat, ns);
        chk($sformatf("r%0d_%0d_D", SWS[k], i), d_v[k], ed);
        chk($sformatf("r%0d_%0d_Bout", SWS[k], i),
            {31'd0, bout_v[k]}, {31'd0, ebo});
        chk($sformatf("r%0d_%0d_zero", SWS[k], i),
            {31'd0, zero_v[k]}, {31'd0, ez});
        chk($sformatf("r%0d_%0d_ovf", SWS[k], i),
            {31'd0, ovf_v[k]}, {31'd0, eov});
        if (i < nops - 1) begin
          ra   = $urandom;
          rb   = ($urandom_range(0, 7) == 0) ? ra : 32'($urandom);
          rbin = 1'($urandom_range(0, 1));
          model(ra, rb, rbin, ed, ebo, ez, eov);
          issue(k, ra, rb, rbin);
        end
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_sub32.md
SEQ_SUB32 -- requirements
Module: seq_sub32

Interface
REQ-001 SHALL provide parameter SLICE_W, default 8: bits subtracted per clock; legal values 1, 2, 4, 8, 16, 32.
REQ-002 SHALL provide clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide start  input  1  request to begin a subtraction; sampled on the rising edge of clk.
REQ-005 SHALL provide a  input  32  minuend, captured when start is accepted.
REQ-006 SHALL provide b  input  32  subtrahend, captured when start is accepted.
REQ-007 SHALL provide Bin  input  1  borrow-in, captured when start is accepted.
REQ-008 SHALL provide busy  output  1  high while an operation is in progress.
REQ-009 SHALL provide done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL provide D  output  32  difference.
REQ-011 SHALL provide Bout  output  1  borrow-out; unsigned a < b + Bin.
REQ-012 SHALL provide zero  output  1  D == 0.
REQ-013 SHALL provide ovf  output  1  signed two's-complement overflow.

Function
REQ-014 SHALL compute D = (a - b - Bin) mod 2^32 over captured operands.
REQ-015 SHALL implement states IDLE, RUN, DONE.
- IDLE->RUN on start.
- RUN->DONE after the last slice.
- DONE->RUN on start, else DONE->IDLE.
REQ-016 SHALL accept start only in IDLE or DONE; start during RUN is ignored and captured operands are unchanged.
REQ-017 SHALL process slice k = bits [k*SLICE_W +: SLICE_W], LSB slice first, one slice per edge in RUN, chaining the registered borrow between slices.
REQ-018 SHALL assert done for exactly one cycle, 32/SLICE_W rising edges after the edge that accepted start; busy is high in RUN only.
REQ-019 SHALL hold D, Bout, zero and ovf stable from done until the edge that accepts the next start; D may change during RUN.
REQ-020 SHALL set ovf = (a[31] != b[31]) && (D[31] != a[31]), with Bin included in D.
REQ-021 SHALL support back-to-back operation: start asserted during the done cycle begins a new operation with no idle cycle.
REQ-022 With SLICE_W=32, the operation SHALL complete in one RUN cycle, with done on the next edge.

Reset
REQ-023 On rst: state=IDLE; busy=0, done=0, D=0, Bout=0, zero=0, ovf=0; slice counter and borrow register cleared.
REQ-024 rst asserted mid-operation SHALL abort the operation; no done pulse for it, and the first start after rst deasserts is accepted normally.

Configuration
REQ-025 Macro SEQ_SUB32_FLAGS_EN defined: zero and ovf SHALL be computed per REQ-012 and REQ-020.
REQ-026 Macro SEQ_SUB32_FLAGS_EN undefined: zero and ovf SHALL be tied 0 and their logic omitted; D and Bout are unaffected and the port list is unchanged.

Structure
REQ-027 Package sub32_pkg SHALL hold the WIDTH=32 constant and the state enum typedef (IDLE, RUN, DONE).
REQ-028 SHALL instantiate one combinational sub-module sub_slice (SLICE_W-bit a, b, borrow-in; difference and borrow-out); no other sub-modules.

Verification
REQ-029 SLICE_W=8, a=5, b=3, Bin=0 -> done 4 edges after start; D=0x00000002, Bout=0, zero=0, ovf=0.
REQ-030 a=0, b=1, Bin=0 -> D=0xFFFFFFFF, Bout=1, ovf=0; and a=0x80000000, b=1 -> D=0x7FFFFFFF, Bout=0, ovf=1 (flags enabled).
REQ-031 a=b=0x12345678, Bin=1 -> D=0xFFFFFFFF, Bout=1; a=b=0x12345678, Bin=0 -> D=0, zero=1 (flags enabled) / zero=0 (flags disabled).
REQ-032 start pulsed again 2 cycles into RUN with different operands -> ignored; first result delivered unchanged, single done pulse.
REQ-033 rst asserted 2 cycles after start -> all outputs 0 immediately, no done; new start after release (a=10, b=4) -> D=6 on schedule.
REQ-034 back-to-back starts in done cycles, repeated for SLICE_W in {1, 4, 32} -> done spacing 32/SLICE_W + 1 cycles, results match the reference model for 1000 random operands.
